// File: rtl/kfx86_iterative_shifter_pkg.sv
// Shared definitions for the KFX86 shift/rotate engine.
// Contents: the flags_t payload, the 3-bit shift opcodes, the FSM state
// encoding, and a helper that classifies an opcode as a shift.
package kfx86_iterative_shifter_pkg;

    // Architectural flags carried alongside ALU/shifter results.
    typedef struct packed {
        logic o;
        logic d;
        logic i;
        logic t;
        logic s;
        logic z;
        logic a;
        logic p;
        logic c;
    } flags_t;

    localparam logic [2:0] OP_ROL = 3'd0;
    localparam logic [2:0] OP_ROR = 3'd1;
    localparam logic [2:0] OP_RCL = 3'd2;
    localparam logic [2:0] OP_RCR = 3'd3;
    localparam logic [2:0] OP_SHL = 3'd4;
    localparam logic [2:0] OP_SHR = 3'd5;
    localparam logic [2:0] OP_SAL = 3'd6;
    localparam logic [2:0] OP_SAR = 3'd7;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_SHIFT = 2'd1;
    localparam logic [1:0] STATE_DONE  = 2'd2;

    // Opcodes 4..7 are true shifts; they rewrite s, z and p.
    function automatic logic is_shift(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/kfx86_shift_step.sv
// Single-bit shift/rotate step (purely combinational).
// Ports:
//   opcode      shift opcode
//   select_word 1 = DATA_WIDTH operand, 0 = byte operand in bits [7:0]
//   v, c        working value and carry before the step
//   v_next_c    working value after the step (bits above the operand are 0)
//   c_next_c    carry after the step
//   o_c         overflow as it would be reported if this is the final step
module kfx86_shift_step
    import kfx86_iterative_shifter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [2:0]            opcode,
    input  logic                  select_word,
    input  logic [DATA_WIDTH-1:0] v,
    input  logic                  c,
    output logic [DATA_WIDTH-1:0] v_next_c,
    output logic                  c_next_c,
    output logic                  o_c
);

    localparam int unsigned DW = DATA_WIDTH;

    logic [DW-1:0] vw;
    logic          cw;
    logic [7:0]    vb;
    logic          cb;
    logic          msb_new;
    logic          msb2_new;
    logic          msb_old;

    // Word-width and byte-width results are formed side by side and muxed.
    always_comb begin
        vw = v;
        cw = c;
        vb = v[7:0];
        cb = c;
        case (opcode)
            OP_ROL: begin
                cw = v[DW-1];
                vw = {v[DW-2:0], v[DW-1]};
                cb = v[7];
                vb = {v[6:0], v[7]};
            end
            OP_ROR: begin
                cw = v[0];
                vw = {v[0], v[DW-1:1]};
                cb = v[0];
                vb = {v[0], v[7:1]};
            end
            OP_RCL: begin
                {cw, vw} = {v, c};
                {cb, vb} = {v[7:0], c};
            end
            OP_RCR: begin
                {vw, cw} = {c, v};
                {vb, cb} = {c, v[7:0]};
            end
            OP_SHL, OP_SAL: begin
                {cw, vw} = {v, 1'b0};
                {cb, vb} = {v[7:0], 1'b0};
            end
            OP_SHR: begin
                {vw, cw} = {1'b0, v};
                {vb, cb} = {1'b0, v[7:0]};
            end
            OP_SAR: begin
                {vw, cw} = {v[DW-1], v};
                {vb, cb} = {v[7], v[7:0]};
            end
            default: begin
                vw = v;
                cw = c;
                vb = v[7:0];
                cb = c;
            end
        endcase
    end

    assign v_next_c = select_word ? vw : DW'(vb);
    assign c_next_c = select_word ? cw : cb;
    assign msb_new  = select_word ? vw[DW-1] : vb[7];
    assign msb2_new = select_word ? vw[DW-2] : vb[6];
    assign msb_old  = select_word ? v[DW-1]  : v[7];

    // Overflow depends only on the last step taken.
    always_comb begin
        o_c = 1'b0;
        case (opcode)
            OP_ROL, OP_RCL, OP_SHL, OP_SAL: o_c = c_next_c ^ msb_new;
            OP_ROR, OP_RCR:                 o_c = msb_new ^ msb2_new;
            OP_SHR:                         o_c = msb_old;
            default:                        o_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/kfx86_iterative_shifter.sv
// Multi-cycle shift/rotate engine: one bit-step per clock, start/busy/done
// handshake towards the microcode sequencer.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   start            request, sampled only while idle
//   opcode           ROL/ROR/RCL/RCR/SHL/SHR/SAL/SAR
//   select_word      1 = DATA_WIDTH operand, 0 = byte operand
//   source, count    operand and shift count
//   source_flags     flags before the operation
//   busy             high while bit-steps are in progress
//   done             one-cycle pulse, out/out_flags valid
//   out, out_flags   result, held until the next completion
module kfx86_iterative_shifter
    import kfx86_iterative_shifter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned MASK_COUNT  = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0]             opcode,
    input  logic                   select_word,
    input  logic [DATA_WIDTH-1:0]  source,
    input  logic [COUNT_WIDTH-1:0] count,
    input  flags_t                 source_flags,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  out,
    output flags_t                 out_flags
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned CW = COUNT_WIDTH;

    logic [1:0]    state_q,     state_d;
    logic [2:0]    op_q,        op_d;
    logic          word_q,      word_d;
    logic [DW-1:0] v_q,         v_d;
    logic          c_q,         c_d;
    flags_t        flags_q,     flags_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic          busy_d;
    logic          done_d;
    logic [DW-1:0] out_d;
    flags_t        out_flags_d;

    logic [DW-1:0] source_masked;
    logic [CW-1:0] effective_count;
    logic [DW-1:0] step_v;
    logic          step_c;
    logic          step_o;
    logic          step_msb;
    flags_t        result_flags;

    assign source_masked   = select_word ? source : DW'(source[7:0]);
    assign effective_count = (MASK_COUNT != 0) ? CW'(count[4:0]) : count;

    kfx86_shift_step #(
        .DATA_WIDTH (DW)
    ) u_step (
        .opcode      (op_q),
        .select_word (word_q),
        .v           (v_q),
        .c           (c_q),
        .v_next_c    (step_v),
        .c_next_c    (step_c),
        .o_c         (step_o)
    );

    assign step_msb = word_q ? step_v[DW-1] : step_v[7];

    // Flags reported when the current step is the final one.
    always_comb begin
        result_flags   = flags_q;
        result_flags.c = step_c;
        result_flags.o = step_o;
        if (is_shift(op_q)) begin
            result_flags.s = step_msb;
            result_flags.z = (step_v == '0);
            result_flags.p = ~^step_v[7:0];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        word_d      = word_q;
        v_d         = v_q;
        c_d         = c_q;
        flags_d     = flags_q;
        remaining_d = remaining_q;
        out_d       = out;
        out_flags_d = out_flags;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (start) begin
                    op_d        = opcode;
                    word_d      = select_word;
                    v_d         = source_masked;
                    c_d         = source_flags.c;
                    flags_d     = source_flags;
                    remaining_d = effective_count;
                    if (effective_count == '0) begin
                        state_d     = STATE_DONE;
                        out_d       = source_masked;
                        out_flags_d = source_flags;
                    end else begin
                        state_d = STATE_SHIFT;
                    end
                end
            end
            STATE_SHIFT: begin
                v_d         = step_v;
                c_d         = step_c;
                remaining_d = remaining_q - CW'(1);
                if (remaining_q == CW'(1)) begin
                    state_d     = STATE_DONE;
                    out_d       = step_v;
                    out_flags_d = result_flags;
                end
            end
            STATE_DONE: begin
                state_d = STATE_IDLE;
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
        busy_d = (state_d == STATE_SHIFT);
        done_d = (state_d == STATE_DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= STATE_IDLE;
            op_q        <= 3'd0;
            word_q      <= 1'b0;
            v_q         <= '0;
            c_q         <= 1'b0;
            flags_q     <= '0;
            remaining_q <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            out         <= '0;
            out_flags   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            word_q      <= word_d;
            v_q         <= v_d;
            c_q         <= c_d;
            flags_q     <= flags_d;
            remaining_q <= remaining_d;
            busy        <= busy_d;
            done        <= done_d;
            out         <= out_d;
            out_flags   <= out_flags_d;
        end
    end

endmodule

// File: doc/kfx86_iterative_shifter.md
Name: kfx86_iterative_shifter

Overview:
- Multi-cycle shift/rotate engine for the KFX86 execution unit: ROL, ROR, RCL, RCR, SHL/SAL, SHR, SAR by an arbitrary count (the CL-count forms), one bit-step per clock.
- Parametrised data width and count width, with optional 80186-style count masking.
- Sits beside the single-step combinational ALU and is driven by the microcode sequencer through a start/busy/done handshake.
- Updates carry, overflow, sign, zero and parity; word and byte modes.

Parameters:
- DATA_WIDTH, 16, operand width in word mode; legal values 16 or 32. Byte mode always uses bits [7:0].
- COUNT_WIDTH, 8, width of the count input.
- MASK_COUNT, 0, when 1 the effective count is count[4:0]; when 0 the full count is used.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- opcode  input  3  0 ROL, 1 ROR, 2 RCL, 3 RCR, 4 SHL, 5 SHR, 6 SAL (=SHL), 7 SAR.
- select_word  input  1  1 = DATA_WIDTH operand, 0 = byte operand.
- source  input  DATA_WIDTH  operand.
- count  input  COUNT_WIDTH  shift count.
- source_flags  input  flags_t  flags before the operation.
- busy  output  1  high from the cycle after an accepted start until done is asserted.
- done  output  1  one-cycle pulse; out and out_flags are valid in this cycle.
- out  output  DATA_WIDTH  result; held until the next accepted start.
- out_flags  output  flags_t  result flags; held until the next accepted start.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - busy = 0, done = 0, out = 0, out_flags = all zero.
  - Applies equally mid-operation; any in-flight operation is discarded.
- Operand width: N = select_word ? DATA_WIDTH : 8.
  - Operand capture: source[N-1:0] is latched; higher bits are treated as 0.
  - Output: out bits above N-1 are always 0; the MSB is bit N-1.
- State machine states: IDLE, SHIFT, DONE.
- IDLE:
  - On start = 1, latch opcode, select_word, source, source_flags and effective count EC.
  - EC = MASK_COUNT ? count[4:0] : count.
  - EC = 0 → go to DONE. Otherwise → go to SHIFT with remaining = EC.
- SHIFT:
  - Each clock edge applies one single-bit step to the working value and carry.
  - remaining decrements by 1 per step; when remaining reaches 0 at that edge → go to DONE.
  - busy = 1 throughout SHIFT.
- DONE:
  - done = 1, busy = 0 for exactly one cycle, then return to IDLE.
  - out and out_flags are registered and hold until the next accepted start.
- Latency: done is asserted EC+1 cycles after the start cycle.
  - Back-to-back: a start in the cycle after done is accepted.
  - A start while not in IDLE (including the DONE cycle) is ignored.
- Single-bit step, with working value v and carry c:
  - ROL: c = v[N-1], v = {v[N-2:0], v[N-1]}.
  - ROR: c = v[0], v = {v[0], v[N-1:1]}.
  - RCL: {c, v} = {v, c}.
  - RCR: {v, c} = {c, v}.
  - SHL/SAL: {c, v} = {v, 0}.
  - SHR: {v, c} = {0, v}.
  - SAR: {v, c} = {v[N-1], v}.
  - The initial c is source_flags.c.
- Flags when EC = 0: out = source (masked to N), out_flags = source_flags.
- Flags when EC ≠ 0:
  - c = last bit shifted out.
  - o is computed from the final step only:
    - left ops: c ^ v[N-1].
    - ROR/RCR: v[N-1] ^ v[N-2].
    - SHR: MSB of the value before the final step.
    - SAR: 0.
  - Shifts (SHL/SAL/SHR/SAR) also set s = v[N-1], z = (v == 0), p = even parity of v[7:0].
  - Rotates leave s, z and p from source_flags.
  - a, d, i, t are always copied from source_flags.

Decomposition:
- Shared header with the existing ALU definitions carries:
  - flags_t.
  - The 3-bit shift opcode constants.
  - The state encoding.
- Natural sub-module: kfx86_shift_step.
  - Purely combinational one-bit step.
  - Inputs: opcode, N-select, v, c.
  - Outputs: next v, next c, o.
  - The sequential wrapper instantiates it once.

Test Plan:
- SHL word, source 16'h8001, count 1, flags 0 → done 2 cycles after start; out 16'h0002, c=1, o=1, s=0, z=0, p=0.
- ROR byte, source 16'h0081, count 4 → done 5 cycles after start; out 16'h0018, c=0, o=0.
- SAR word, source 16'h8000, count 15 → out 16'hFFFF, c=0, o=0, s=1, z=0, p=1; busy high for exactly 15 cycles.
- count 0, SHR word, source 16'h1234, source_flags.c=1, z=1 → done 1 cycle after start; out 16'h1234, out_flags = source_flags.
- RCL byte, source 16'h0080, c=0, count 9 → out 16'h0080, c=0. With MASK_COUNT=1 and count 33 (EC=1), SHL 16'h4000 → out 16'h8000, o=1.
- SHR word, count 200: pulse start again at cycle 3 → ignored. Assert reset at cycle 10 → busy=0, done=0, out=0 immediately. After release, start SHR 16'h0004 count 2 → out 16'h0001.
